key_expansion_ctrl: RTL and testbench

- Sequencer for AES-128 key expansion.
- Accepts a 128-bit cipher key and drives the shared G-function unit (RotWord/SubWord/Rcon) once per round, for rounds 1..10.
- XOR-chains each G result into the four words of the next round key and stores all 11 round keys.
- Sits between the key-load interface and the cipher round datapath, which reads round keys by index.

---
 rtl/keyexp_pkg.sv | 41 ++++
 rtl/key_expansion_ctrl_if.sv | 26 ++
 rtl/keyexp_rk_store.sv | 39 +++
 rtl/key_expansion_ctrl.sv | 172 +++++++++++++++++
 tb/tb_key_expansion_ctrl.sv | 341 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/keyexp_pkg.sv
// ---------------------------------------------------------------------------
// keyexp_pkg
// Shared definitions for the AES-128 key expansion sequencer:
//   - NUM_ROUNDS / NUM_KEYS / WDOG_LIMIT constants
//   - round_key_t (one 128-bit round key, w0 in [127:96])
//   - state_t FSM encoding (ST_ERR is only reachable when KEYEXP_WDOG_EN
//     is defined)
//   - next_round_key(): the word XOR chain that turns the previous round
//     key and the G result into the next round key
// ---------------------------------------------------------------------------
package keyexp_pkg;

   localparam int NUM_ROUNDS = 10;
   localparam int NUM_KEYS   = NUM_ROUNDS + 1;
   localparam int WDOG_LIMIT = 64;

   typedef logic [127:0] round_key_t;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LOAD   = 3'd1,
      ST_GREQ   = 3'd2,
      ST_GWAIT  = 3'd3,
      ST_EXPAND = 3'd4,
      ST_DONE   = 3'd5,
      ST_ERR    = 3'd6
   } state_t;

   // Each word of the new key is the matching word of the previous key XORed
   // with the new word to its left; w0 takes the G result instead.
   function automatic round_key_t next_round_key(input round_key_t  p,
                                                 input logic [31:0] t);
      logic [31:0] w0, w1, w2, w3;
      w0 = p[127:96] ^ t;
      w1 = p[95:64]  ^ w0;
      w2 = p[63:32]  ^ w1;
      w3 = p[31:0]   ^ w2;
      return {w0, w1, w2, w3};
   endfunction

endpackage

// File: rtl/key_expansion_ctrl_if.sv
// ---------------------------------------------------------------------------
// key_expansion_ctrl_if
// Handshake between the key expansion sequencer and the shared G unit
// (RotWord / SubWord / Rcon).
//   g_enable : one-cycle request from the sequencer
//   g_in     : input word w[4i-1], held stable until g_done
//   g_round  : round number for Rcon, 1..10
//   g_out    : G result, valid while g_done = 1
//   g_done   : one-cycle completion pulse from the G unit
// master = sequencer side, slave = G unit side.
// ---------------------------------------------------------------------------
interface key_expansion_ctrl_if;

   logic        g_enable;
   logic [31:0] g_in;
   logic [3:0]  g_round;
   logic [31:0] g_out;
   logic        g_done;

   modport master (output g_enable, g_in, g_round,
                   input  g_out, g_done);

   modport slave  (input  g_enable, g_in, g_round,
                   output g_out, g_done);

endinterface

// File: rtl/keyexp_rk_store.sv
// ---------------------------------------------------------------------------
// keyexp_rk_store
// Round key register file: NUM_KEYS x 128 bits, one synchronous write port
// and one combinational read port. Reads above the last entry return 0.
//   clk, n_rst     : clock, asynchronous active-low reset (clears all keys)
//   we/waddr/wdata : write port
//   raddr/rdata    : combinational read port
// ---------------------------------------------------------------------------
module keyexp_rk_store
   import keyexp_pkg::*;
(
   input  logic       clk,
   input  logic       n_rst,
   input  logic       we,
   input  logic [3:0] waddr,
   input  round_key_t wdata,
   input  logic [3:0] raddr,
   output round_key_t rdata
);

   round_key_t mem [NUM_KEYS];

   // NOTE: the array is held in flops and cleared by reset, because an abort
   // must leave no stale key readable; it is not a RAM macro.
   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         for (int i = 0; i < NUM_KEYS; i++) mem[i] <= '0;
      end else if (we && (waddr < 4'(NUM_KEYS))) begin
         mem[waddr] <= wdata;
      end
   end

   always_comb begin
      rdata = '0;
      if (raddr < 4'(NUM_KEYS)) rdata = mem[raddr];
   end

endmodule

// File: rtl/key_expansion_ctrl.sv
// ---------------------------------------------------------------------------
// key_expansion_ctrl
// AES-128 key expansion sequencer. Captures the cipher key into rk[0], then
// for rounds 1..10 requests G(w[4i-1]) from the shared G unit and XOR-chains
// the result into rk[i]. Round keys are read combinationally by index.
//   clk, n_rst  : clock, asynchronous active-low reset
//   start       : request expansion (sampled only in IDLE)
//   key_in      : cipher key, w0 in [127:96]
//   busy        : high from LOAD through DONE
//   done        : one-cycle pulse when rk[10] is written
//   keys_valid  : rk[0..10] valid, sticky until next accepted start
//   err         : watchdog abort flag (constant 0 without KEYEXP_WDOG_EN)
//   rk_addr     : round key read index
//   rk_data     : rk[rk_addr], 0 when rk_addr > 10
//   g_bus       : master side of the G unit handshake
// Optional feature: define KEYEXP_WDOG_EN to add a GWAIT watchdog that
// aborts into ERR after WDOG_LIMIT cycles without g_done.
// ---------------------------------------------------------------------------
module key_expansion_ctrl
   import keyexp_pkg::*;
(
   input  logic       clk,
   input  logic       n_rst,
   input  logic       start,
   input  round_key_t key_in,
   output logic       busy,
   output logic       done,
   output logic       keys_valid,
   output logic       err,
   input  logic [3:0] rk_addr,
   output round_key_t rk_data,
   key_expansion_ctrl_if.master g_bus
);

   state_t      state, state_nxt;
   logic [3:0]  round;
   round_key_t  prev;       // rk[round-1], kept locally so the read port stays free
   round_key_t  nxt;
   logic [31:0] t;
   logic        g_en_q;
   logic [31:0] g_in_q;
   logic [3:0]  g_round_q;
   logic        keys_valid_q;
   logic        last_round;
   logic        wdog_hit;

   logic        wr_en;
   logic [3:0]  wr_addr;
   round_key_t  wr_data;

   assign nxt        = next_round_key(prev, t);
   assign last_round = (round == 4'(NUM_ROUNDS));

`ifdef KEYEXP_WDOG_EN
   logic [6:0] wdog;        // cycles already spent in the current GWAIT
   logic       err_q;

   assign wdog_hit = (wdog == 7'(WDOG_LIMIT - 1));

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         wdog  <= '0;
         err_q <= 1'b0;
      end else begin
         wdog <= (state == ST_GWAIT) ? wdog + 7'd1 : 7'd0;
         if (state == ST_IDLE && start) err_q <= 1'b0;
         else if (state_nxt == ST_ERR)  err_q <= 1'b1;
      end
   end

   assign err = err_q;
`else
   assign wdog_hit = 1'b0;
   assign err      = 1'b0;
`endif

   // NOTE: every output of a combinational block gets a default first so no
   // path leaves it unassigned (which would infer a latch).
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:   if (start) state_nxt = ST_LOAD;
         ST_LOAD:   state_nxt = ST_GREQ;
         ST_GREQ:   state_nxt = ST_GWAIT;
         ST_GWAIT: begin
            if (g_bus.g_done) state_nxt = ST_EXPAND;
`ifdef KEYEXP_WDOG_EN
            else if (wdog_hit) state_nxt = ST_ERR;
`endif
         end
         ST_EXPAND: state_nxt = last_round ? ST_DONE : ST_GREQ;
         ST_DONE:   state_nxt = ST_IDLE;
         default:   state_nxt = ST_IDLE;
      endcase
   end

   // rk[0] is written on the accepting edge, rk[round] at the end of EXPAND.
   always_comb begin
      wr_en   = 1'b0;
      wr_addr = '0;
      wr_data = '0;
      if (state == ST_IDLE && start) begin
         wr_en   = 1'b1;
         wr_data = key_in;
      end else if (state == ST_EXPAND) begin
         wr_en   = 1'b1;
         wr_addr = round;
         wr_data = nxt;
      end
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state        <= ST_IDLE;
         round        <= '0;
         prev         <= '0;
         t            <= '0;
         g_en_q       <= 1'b0;
         g_in_q       <= '0;
         g_round_q    <= '0;
         keys_valid_q <= 1'b0;
      end else begin
         state  <= state_nxt;
         g_en_q <= (state_nxt == ST_GREQ);
         case (state)
            ST_IDLE: if (start) begin
               round        <= 4'd1;
               prev         <= key_in;
               keys_valid_q <= 1'b0;
            end
            // g_in/g_round are loaded one cycle ahead of GREQ and held
            // through GWAIT.
            ST_LOAD: begin
               g_in_q    <= prev[31:0];
               g_round_q <= round;
            end
            ST_GWAIT: if (g_bus.g_done) t <= g_bus.g_out;
            ST_EXPAND: begin
               prev <= nxt;
               if (last_round) begin
                  keys_valid_q <= 1'b1;
               end else begin
                  round     <= round + 4'd1;
                  g_in_q    <= nxt[31:0];
                  g_round_q <= round + 4'd1;
               end
            end
            ST_ERR: keys_valid_q <= 1'b0;
            default: ;
         endcase
      end
   end

   assign busy = state inside {ST_LOAD, ST_GREQ, ST_GWAIT, ST_EXPAND, ST_DONE};
   assign done = (state == ST_DONE);
   assign keys_valid = keys_valid_q;

   assign g_bus.g_enable = g_en_q;
   assign g_bus.g_in     = g_in_q;
   assign g_bus.g_round  = g_round_q;

   keyexp_rk_store u_rk_store (
      .clk   (clk),
      .n_rst (n_rst),
      .we    (wr_en),
      .waddr (wr_addr),
      .wdata (wr_data),
      .raddr (rk_addr),
      .rdata (rk_data)
   );

endmodule

// File: tb/tb_key_expansion_ctrl.sv
// ---------------------------------------------------------------------------
// tb_key_expansion_ctrl
// Bench for key_expansion_ctrl with a behavioural AES G unit (latency 12).
// Expected round keys and expected G requests are queued when an expansion
// is started and compared when the DUT produces them. Define KEYEXP_WDOG_EN
// to also exercise the watchdog abort.
// ---------------------------------------------------------------------------
module tb_key_expansion_ctrl;
   import keyexp_pkg::*;

   localparam logic [127:0] ZERO     = '0;
   localparam logic [127:0] ONE      = 128'd1;
   localparam round_key_t   FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam int           G_LAT    = 12;

   typedef struct {
      logic [3:0] addr;
      round_key_t data;
   } rk_exp_t;

   typedef struct {
      logic [3:0]  rnd;
      logic [31:0] win;
   } g_exp_t;

   logic       clk;
   logic       n_rst;
   logic       start;
   round_key_t key_in;
   logic       busy, done, keys_valid, err;
   logic [3:0] rk_addr;
   round_key_t rk_data;

   key_expansion_ctrl_if ifc ();

   key_expansion_ctrl dut (
      .clk        (clk),
      .n_rst      (n_rst),
      .start      (start),
      .key_in     (key_in),
      .busy       (busy),
      .done       (done),
      .keys_valid (keys_valid),
      .err        (err),
      .rk_addr    (rk_addr),
      .rk_data    (rk_data),
      .g_bus      (ifc)
   );

   int          cmp_cnt = 0;
   int          fail_cnt = 0;
   int          cyc = 0;
   int          t0 = 0;
   int          en_cnt = 0;
   bit          g_hang = 0;
   rk_exp_t     rk_q[$];
   g_exp_t      g_q[$];
   logic [31:0] m_w [44];

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not reach its summary");
      $fatal(1, "timeout");
   end

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      cmp_cnt++;
      assert (obs === exp) else begin
         fail_cnt++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // ---------------- AES reference arithmetic ----------------
   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, aa, bb;
      p = 8'h00; aa = a; bb = b;
      for (int i = 0; i < 8; i++) begin
         if (bb[0]) p = p ^ aa;
         aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
         bb = bb >> 1;
      end
      return p;
   endfunction

   function automatic logic [7:0] sbox(input logic [7:0] x);
      logic [7:0] inv;
      inv = 8'h01;
      for (int i = 0; i < 254; i++) inv = gmul(inv, x);   // x^254 = x^-1, 0 -> 0
      return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                 ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
   endfunction

   function automatic logic [7:0] rcon(input logic [3:0] r);
      logic [7:0] x;
      x = 8'h01;
      for (int i = 1; i < int'(r); i++) x = gmul(x, 8'h02);
      return x;
   endfunction

   function automatic logic [31:0] g_func(input logic [31:0] w, input logic [3:0] r);
      logic [31:0] rot, s;
      rot = {w[23:0], w[31:24]};
      for (int i = 0; i < 4; i++) s[8*i +: 8] = sbox(rot[8*i +: 8]);
      return s ^ {rcon(r), 24'h000000};
   endfunction

   // Word-oriented reference expansion into m_w[0..43].
   task automatic model_expand(input round_key_t key);
      logic [31:0] tmp;
      m_w[0] = key[127:96]; m_w[1] = key[95:64];
      m_w[2] = key[63:32];  m_w[3] = key[31:0];
      for (int i = 4; i < 44; i++) begin
         tmp = m_w[i-1];
         if (i % 4 == 0) tmp = g_func(tmp, 4'(i / 4));
         m_w[i] = m_w[i-4] ^ tmp;
      end
   endtask

   task automatic push_g_exp(input round_key_t key);
      g_exp_t e;
      model_expand(key);
      for (int r = 1; r <= NUM_ROUNDS; r++) begin
         e.rnd = 4'(r);
         e.win = m_w[4*r-1];
         g_q.push_back(e);
      end
   endtask

   task automatic push_rk(input logic [3:0] a, input round_key_t d);
      rk_exp_t e;
      e.addr = a;
      e.data = d;
      rk_q.push_back(e);
   endtask

   // ---------------- G unit model ----------------
   initial begin
      logic [31:0] cap_in;
      logic [3:0]  cap_rnd;
      bit          aborted;
      g_exp_t      e;
      ifc.g_done = 1'b0;
      ifc.g_out  = '0;
      forever begin
         @(negedge clk);
         if (n_rst && ifc.g_enable) begin
            en_cnt++;
            cap_in  = ifc.g_in;
            cap_rnd = ifc.g_round;
            if (!g_hang) begin
               check("g_queue_has_entry", 128'(g_q.size() != 0), ONE);
               if (g_q.size() != 0) begin
                  e = g_q.pop_front();
                  check("g_round", 128'(cap_rnd), 128'(e.rnd));
                  check("g_in", 128'(cap_in), 128'(e.win));
               end
            end
            @(negedge clk);
            check("g_enable_width", 128'(ifc.g_enable), ZERO);
            if (!g_hang) begin
               aborted = !n_rst;
               for (int i = 2; i <= G_LAT && !aborted; i++) begin
                  @(negedge clk);
                  if (!n_rst) aborted = 1;
               end
               if (!aborted) begin
                  check("g_in_stable", 128'(ifc.g_in), 128'(cap_in));
                  check("g_round_stable", 128'(ifc.g_round), 128'(cap_rnd));
                  ifc.g_out  = g_func(cap_in, cap_rnd);
                  ifc.g_done = 1'b1;
                  @(negedge clk);
                  ifc.g_done = 1'b0;
               end
            end
         end
      end
   end

   // ---------------- directed helpers ----------------
   task automatic read_rk(input logic [3:0] a, output round_key_t d);
      rk_addr = a;
      #1;
      d = rk_data;
   endtask

   task automatic pulse_start(input round_key_t key);
      @(negedge clk);
      key_in = key;
      start  = 1'b1;
      t0     = cyc;
      en_cnt = 0;
      @(negedge clk);
      start = 1'b0;
      check("busy_in_load", 128'(busy), ONE);
      check("keys_valid_cleared", 128'(keys_valid), ZERO);
      check("err_cleared", 128'(err), ZERO);
   endtask

   task automatic finish_run(input string tag);
      bit         seen;
      int         lat;
      rk_exp_t    e;
      round_key_t rd;
      seen = 0;
      for (int i = 0; i < 200 && !seen; i++) begin
         @(negedge clk);
         if (done) seen = 1;
      end
      lat = cyc - t0;
      check({tag, "_done_seen"}, 128'(seen), ONE);
      if (seen) begin
         check({tag, "_latency"}, 128'(lat), 128'(10 * (G_LAT + 2) + 2));
         check({tag, "_keys_valid_at_done"}, 128'(keys_valid), ONE);
         @(negedge clk);
         check({tag, "_done_one_cycle"}, 128'(done), ZERO);
         check({tag, "_busy_after"}, 128'(busy), ZERO);
         check({tag, "_keys_valid_sticky"}, 128'(keys_valid), ONE);
         check({tag, "_g_enable_count"}, 128'(en_cnt), 128'(NUM_ROUNDS));
         check({tag, "_g_queue_drained"}, 128'(g_q.size()), ZERO);
      end
      while (rk_q.size() != 0) begin
         e = rk_q.pop_front();
         read_rk(e.addr, rd);
         check($sformatf("%s_rk%0d", tag, e.addr), rd, e.data);
      end
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      round_key_t rd;
      bit         found;

      n_rst = 1'b0; start = 1'b0; key_in = '0; rk_addr = '0;
      repeat (3) @(negedge clk);
      check("rst_busy", 128'(busy), ZERO);
      check("rst_done", 128'(done), ZERO);
      check("rst_keys_valid", 128'(keys_valid), ZERO);
      check("rst_err", 128'(err), ZERO);
      check("rst_g_enable", 128'(ifc.g_enable), ZERO);
      check("rst_g_in", 128'(ifc.g_in), ZERO);
      check("rst_g_round", 128'(ifc.g_round), ZERO);
      read_rk(4'd0, rd);  check("rst_rk0", rd, ZERO);
      read_rk(4'd10, rd); check("rst_rk10", rd, ZERO);
      @(negedge clk);
      n_rst = 1'b1;
      @(negedge clk);

      // FIPS-197 key with real G
      push_g_exp(FIPS_KEY);
      check("model_g_in_r1", 128'(g_q[0].win), 128'(32'h09cf4f3c));
      push_rk(4'd0, FIPS_KEY);
      push_rk(4'd1, 128'ha0fafe1788542cb123a339392a6c7605);
      push_rk(4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
      pulse_start(FIPS_KEY);
      finish_run("fips");

      // out-of-range read indices
      read_rk(4'd11, rd); check("rk_addr_11", rd, ZERO);
      read_rk(4'd15, rd); check("rk_addr_15", rd, ZERO);

      // second start while busy must be ignored
      push_g_exp(ZERO);
      push_rk(4'd0, ZERO);
      push_rk(4'd10, 128'hb4ef5bcb3e92e21123e951cf6f8f188e);
      pulse_start(ZERO);
      repeat (34) @(negedge clk);
      key_in = FIPS_KEY;
      start  = 1'b1;
      @(negedge clk);
      start = 1'b0;
      finish_run("zero_dbl_start");

      // reset in round 6, then restart
      push_g_exp(FIPS_KEY);
      pulse_start(FIPS_KEY);
      found = 0;
      for (int i = 0; i < 200 && !found; i++) begin
         @(negedge clk);
         if (ifc.g_enable && ifc.g_round == 4'd6) found = 1;
      end
      check("reached_round6", 128'(found), ONE);
      n_rst = 1'b0;
      @(negedge clk);
      check("abort_keys_valid", 128'(keys_valid), ZERO);
      check("abort_busy", 128'(busy), ZERO);
      check("abort_g_enable", 128'(ifc.g_enable), ZERO);
      for (int a = 0; a < NUM_KEYS; a++) begin
         read_rk(4'(a), rd);
         check($sformatf("abort_rk%0d", a), rd, ZERO);
      end
      g_q.delete();
      rk_q.delete();
      @(negedge clk);
      n_rst = 1'b1;
      @(negedge clk);
      push_g_exp(FIPS_KEY);
      push_rk(4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
      pulse_start(FIPS_KEY);
      finish_run("restart");

`ifdef KEYEXP_WDOG_EN
      // G never answers: watchdog abort
      g_hang = 1;
      pulse_start(FIPS_KEY);
      found = 0;
      for (int i = 0; i < 20 && !found; i++) begin
         @(negedge clk);
         if (ifc.g_enable) found = 1;
      end
      check("wdog_greq_seen", 128'(found), ONE);
      repeat (WDOG_LIMIT) @(negedge clk);
      check("wdog_err_not_early", 128'(err), ZERO);
      @(negedge clk);
      check("wdog_err_set", 128'(err), ONE);
      check("wdog_busy", 128'(busy), ZERO);
      check("wdog_keys_valid", 128'(keys_valid), ZERO);
      check("wdog_g_enable", 128'(ifc.g_enable), ZERO);
      @(negedge clk);
      check("wdog_err_sticky", 128'(err), ONE);
      check("wdog_idle_busy", 128'(busy), ZERO);
      g_hang = 0;
      push_g_exp(FIPS_KEY);
      push_rk(4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
      pulse_start(FIPS_KEY);
      finish_run("after_wdog");
`endif

      repeat (2) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, fail_cnt);
      $finish;
   end

endmodule
